alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers ALU operations in a small FIFO and issues them one at
// a time to an external combinational ALU. Each result is captured and held
// until the downstream side takes it.
// Optional build macro ALU_ISSUE_STATS_EN adds an 8-bit completed-result
// counter on output op_count.
module alu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [2:0]               in_f,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_f,
    input  logic [WIDTH-1:0]         alu_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic [2:0]               out_f,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [7:0]               op_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 2 * WIDTH + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // FIFO storage: each entry is {f, b, a}
    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    state_t           state_q, state_d;

    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_f_q, alu_f_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic [2:0]       out_f_q, out_f_d;

    logic             push;
    logic             pop;
    logic [EW-1:0]    head;

    // Space check uses only the registered count, so a pop never opens a slot
    // in the same cycle.
    assign in_ready   = (count_q < CW'(DEPTH));
    assign push       = in_valid & in_ready;
    assign head       = mem_q[rd_ptr_q];

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_f      = alu_f_q;
    assign out_valid  = out_valid_q;
    assign out_y      = out_y_q;
    assign out_f      = out_f_q;
    assign fifo_count = count_q;

    // FIFO entry write; storage itself needs no reset since pointers gate use
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_f, in_b, in_a};
        end
    end

    // Issue FSM next-state logic; the FSM is the only source of pops
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_f_d     = out_f_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // ALU has had one full cycle on the registered operands
                out_y_d     = alu_y;
                out_f_d     = alu_f_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand registers load the FIFO head on a pop and otherwise hold
    always_comb begin
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        alu_f_d = alu_f_q;
        if (pop) begin
            alu_a_d = head[WIDTH-1:0];
            alu_b_d = head[2*WIDTH-1:WIDTH];
            alu_f_d = head[EW-1:2*WIDTH];
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_f_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_f_q     <= alu_f_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_f_q     <= out_f_d;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [7:0] op_count_q, op_count_d;

    // Completed-result counter, wraps 255 -> 0
    always_comb begin
        op_count_d = op_count_q + 8'(out_valid_q & out_ready);
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with an adder as the external ALU. Inputs are driven
// on the falling edge; accepted operations push their expected result onto a
// scoreboard which is popped on each output handshake.
module tb_alu_issue_ctrl;
    localparam int DEPTH = 4;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic [2:0]       in_f;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [2:0]       alu_f;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [2:0]       out_f;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef ALU_ISSUE_STATS_EN
    logic [7:0]       op_count;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    int         hs_count = 0;
    logic [6:0] sb [$];
    logic [6:0] exp_r;

    alu_issue_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_f       (in_f),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_y      (alu_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_f      (out_f),
        .fifo_count (fifo_count)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .op_count   (op_count)
`endif
    );

    // External ALU model: 4-bit wrapping add
    assign alu_y = alu_a + alu_b;

    always #5 clk = ~clk;

    // Called at a falling edge with inputs settled: scores a handshake that
    // will complete on the coming rising edge, then advances one cycle.
    task automatic cycle();
        if (rst_n && out_valid && out_ready) begin
            hs_count++;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL result_unexpected: got f=%h y=%h, required no result", out_f, out_y);
            end else begin
                exp_r = sb.pop_front();
                if ({out_f, out_y} !== exp_r) begin
                    n_err++;
                    $display("FAIL result: got f=%h y=%h, required f=%h y=%h",
                             out_f, out_y, exp_r[6:4], exp_r[3:0]);
                end else begin
                    $display("result f=%h y=%h", out_f, out_y);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic push_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
        int         waited = 0;
        bit         done = 1'b0;
        logic [3:0] s;
        s = a + b;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_f = f;
        while (!done) begin
            if (in_ready) begin
                sb.push_back({f, s});
                done = 1'b1;
            end
            cycle();
            waited++;
            if (!done && waited > 100) begin
                n_vec++;
                n_err++;
                $display("FAIL push_timeout: got in_ready=%b, required 1 within 100 cycles", in_ready);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            cycle();
            n++;
        end
        n_vec++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain: got %0d pending out_valid=%b, required 0 pending", sb.size(), out_valid);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        in_f = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({out_valid, out_y, out_f, alu_a, alu_b, alu_f, fifo_count} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b y=%h f=%h a=%h b=%h af=%h cnt=%0d, required all 0",
                     out_valid, out_y, out_f, alu_a, alu_b, alu_f, fifo_count);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        push_op(4'b0011, 4'b0001, 3'b001);
        n_vec++;
        if (fifo_count !== 3'd1 || alu_a !== 4'd0) begin
            n_err++;
            $display("FAIL lat_edge1: got cnt=%0d alu_a=%h, required cnt=1 alu_a=0", fifo_count, alu_a);
        end
        cycle();
        n_vec++;
        if (alu_a !== 4'b0011 || alu_b !== 4'b0001 || alu_f !== 3'b001 || fifo_count !== 3'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lat_edge2: got a=%h b=%h f=%h cnt=%0d v=%b, required a=3 b=1 f=1 cnt=0 v=0",
                     alu_a, alu_b, alu_f, fifo_count, out_valid);
        end
        cycle();
        n_vec++;
        if (out_valid !== 1'b1 || out_y !== 4'b0100 || out_f !== 3'b001) begin
            n_err++;
            $display("FAIL lat_edge3: got v=%b y=%h f=%h, required v=1 y=4 f=1", out_valid, out_y, out_f);
        end
        drain();
        n_vec++;
        if (alu_a !== 4'b0011 || alu_f !== 3'b001) begin
            n_err++;
            $display("FAIL alu_hold: got a=%h f=%h, required a=3 f=1", alu_a, alu_f);
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_op(4'(i + 1), 4'(2 * i + 7), 3'(i));
        end
        n_vec++;
        if (fifo_count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fill_full: got cnt=%0d in_ready=%b v=%b, required cnt=4 in_ready=0 v=1",
                     fifo_count, in_ready, out_valid);
        end
        out_ready = 1'b1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fill_same_cycle: got in_ready=%b, required 0", in_ready);
        end
        cycle();
        n_vec++;
        if (in_ready !== 1'b1 || fifo_count !== 3'd3) begin
            n_err++;
            $display("FAIL fill_next_cycle: got in_ready=%b cnt=%0d, required 1 and 3", in_ready, fifo_count);
        end
        push_op(4'hF, 4'h3, 3'd7);
        drain();
    endtask

    task automatic test_stall();
        int n = 0;
        int hs0;
        out_ready = 1'b0;
        push_op(4'd6, 4'd6, 3'd3);
        push_op(4'd2, 4'd5, 3'd4);
        while (!out_valid && n < 20) begin
            cycle();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_y !== 4'b1100 || out_f !== 3'd3) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b y=%h f=%h, required v=1 y=c f=3",
                         i, out_valid, out_y, out_f);
            end
            cycle();
        end
        hs0 = hs_count;
        drain();
        n_vec++;
        if (hs_count - hs0 !== 2) begin
            n_err++;
            $display("FAIL stall_handshakes: got %0d, required 2", hs_count - hs0);
        end
    endtask

    task automatic test_simul();
        out_ready = 1'b0;
        push_op(4'd1, 4'd1, 3'd1);
        push_op(4'd2, 4'd2, 3'd2);
        push_op(4'd3, 4'd3, 3'd3);
        n_vec++;
        if (fifo_count !== 3'd2 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL simul_pre: got cnt=%0d v=%b, required cnt=2 v=1", fifo_count, out_valid);
        end
        out_ready = 1'b1;
        push_op(4'd9, 4'd9, 3'd5);
        n_vec++;
        if (fifo_count !== 3'd2) begin
            n_err++;
            $display("FAIL simul_count: got %0d, required 2", fifo_count);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int k = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_op(4'(3 * i), 4'(i + 4), 3'(7 - i));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_ready) k++;
            cycle();
        end
        n_vec++;
        if (k !== 5) begin
            n_err++;
            $display("FAIL throughput: got %0d results in 10 cycles, required 5", k);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_op(4'(i), 4'(i), 3'(i));
        end
        out_ready = 1'b1;
        cycle();
        n_vec++;
        if (fifo_count !== 3'd3) begin
            n_err++;
            $display("FAIL rmid_pre: got cnt=%0d, required 3", fifo_count);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || fifo_count !== 3'd0 || alu_a !== 4'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_async: got v=%b cnt=%0d alu_a=%h in_ready=%b, required 0 0 0 1",
                     out_valid, fifo_count, alu_a, in_ready);
        end
        sb.delete();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0 || fifo_count !== 3'd0) seen++;
            cycle();
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL rmid_quiet: got %0d active cycles, required 0", seen);
        end
    endtask

`ifdef ALU_ISSUE_STATS_EN
    task automatic test_stats();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            push_op(4'(i), 4'(i >> 4), 3'(i));
        end
        drain();
        n_vec++;
        if (op_count !== 8'd1) begin
            n_err++;
            $display("FAIL op_count: got %0d, required 1", op_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_stall();
        test_simul();
        test_back_to_back();
        test_reset_mid();
`ifdef ALU_ISSUE_STATS_EN
        test_stats();
`else
        apply_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
